// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: PC redirect plus per-stage stall/flush vectors,
// with a post-redirect flush window. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int NSTAGE    = 4,
  parameter int EX_STAGE  = 2,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_busy_i,
  input  logic              ld_use_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam logic [NSTAGE-1:0] ONES       = {NSTAGE{1'b1}};
  localparam logic [NSTAGE-1:0] BIT0       = {{(NSTAGE-1){1'b0}}, 1'b1};
  localparam logic [NSTAGE-1:0] EX_BIT     = BIT0 << EX_STAGE;
  localparam logic [NSTAGE-1:0] BUSY_STALL = ONES >> (NSTAGE - 1 - EX_STAGE);
  localparam logic [NSTAGE-1:0] BUSY_FLUSH = EX_BIT << 1;
  localparam logic [NSTAGE-1:0] LU_STALL   = ONES >> (NSTAGE - EX_STAGE);
  localparam logic [NSTAGE-1:0] JMP_FLUSH  = BUSY_STALL & ~BIT0;
  localparam logic [3:0]        CNT_INIT   = 4'(FLUSH_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Remembers whether BUSY interrupted a flush window that must resume.
  logic       ret_flush_q, ret_flush_d;
  logic       in_flush_s;

  assign in_flush_s = (state_q == ST_FLUSH) || ((state_q == ST_BUSY) && ret_flush_q);

  // Next-state and output decode; priority busy > jump > load-use.
  always_comb begin
    state_d     = ST_RUN;
    cnt_d       = cnt_q;
    ret_flush_d = ret_flush_q;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    stall_o     = '0;
    flush_o     = '0;
    busy_o      = (state_q != ST_RUN);
    if (ex_busy_i) begin
      stall_o     = BUSY_STALL;
      flush_o     = BUSY_FLUSH;
      ret_flush_d = in_flush_s;
      state_d     = ST_BUSY;
    end else if (jump_en_i) begin
      jump_en_o   = 1'b1;
      jump_addr_o = jump_addr_i;
      flush_o     = JMP_FLUSH;
      cnt_d       = CNT_INIT;
      ret_flush_d = 1'b0;
      state_d     = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
    end else if (in_flush_s) begin
      flush_o     = JMP_FLUSH;
      ret_flush_d = 1'b0;
      if (cnt_q <= 4'd1) begin
        cnt_d   = 4'd0;
        state_d = ST_RUN;
      end else begin
        cnt_d   = cnt_q - 4'd1;
        state_d = ST_FLUSH;
      end
    end else if (ld_use_i) begin
      stall_o     = LU_STALL;
      flush_o     = EX_BIT;
      ret_flush_d = 1'b0;
      state_d     = ST_RUN;
    end else begin
      ret_flush_d = 1'b0;
      state_d     = ST_RUN;
    end
  end

  // FSM state, flush counter and resume flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      ret_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_flush_q <= ret_flush_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Event counters wrap naturally at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (|stall_o) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (|flush_o) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
